// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder and its full-adder cell.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell; combinational only so it can be shared with the subtractor path.
module full_add (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice plus a carry flop, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_c;

  full_add u_slice (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_c)
  );

  // sum_sh keeps only the upper WIDTH-1 partial bits; the new bit enters at the top
  assign sum_nxt = {bit_s, sum_sh};

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST)          state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt[WIDTH-1:1];
          carry  <= bit_c;
          // counter holds at LAST; it is only rewound by the next IDLE load
          if (cnt == LAST) begin
            sum  <= sum_nxt;
            cout <= bit_c;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first N-bit adder. It is the addition counterpart of the team's subtractor cells.
- Accepts two operands plus carry-in through a valid/ready handshake. Computes one bit per clock through a single full-adder cell and a carry flip-flop.
- Presents sum and carry-out through a second valid/ready handshake.
- Intended as the area-minimal arithmetic datapath element for the serial ALU path.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2
CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - Shift registers, carry flop and counter cleared.
  - sum = 0, cout = 0, out_valid = 0, busy = 0.
  - in_ready forced to 0 while rst_n is low.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: load a_sh = a, b_sh = b, carry = cin, cnt = 0; go to SHIFT.
- SHIFT: each edge does the following.
  - s = a_sh[0] ^ b_sh[0] ^ carry; c = majority(a_sh[0], b_sh[0], carry).
  - sum_sh shifts right with s entering at bit WIDTH-1.
  - a_sh and b_sh shift right; carry = c; cnt increments.
  - On the edge where cnt == WIDTH-1: go to DONE, load sum = final sum_sh, cout = c.
- DONE:
  - out_valid = 1; sum and cout held stable.
  - On an edge with out_ready: go to IDLE, out_valid drops.
- Latency:
  - Accept edge at T.
  - out_valid is high after edge T+WIDTH, exactly WIDTH cycles after acceptance.
  - Back-to-back throughput is one result per WIDTH+2 cycles minimum (IDLE costs one cycle).
- in_ready is 0 in SHIFT and DONE. in_valid in those states is ignored. a, b, cin are sampled only at the accept edge; later changes have no effect.
- out_ready asserted in IDLE or SHIFT has no effect.
- out_ready already high when DONE is entered: handshake completes on the next edge, so out_valid is high for exactly one cycle.
- sum and cout keep the last result after DONE is left, until the next DONE load or reset.
- Reset asserted mid-SHIFT or in DONE aborts the operation with no partial result. All outputs return to their reset values immediately; no edge is required.
- Wrap-around: sum is modulo 2^WIDTH. Overflow is reported only through cout; there is no other flag.
- Counter wraps to 0 only through the IDLE load, never by counting past WIDTH-1.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2).
  - localparam default WIDTH.
- Sub-module full_add (inputs x, y, ci; outputs s, co), purely combinational.
  - Instantiated once for the bit slice.
  - Reusable by the subtractor team as the complementary cell.
- Everything else (FSM, shift registers, counter) stays in serial_adder.

Test Plan:
1. WIDTH=8, a=8'd5, b=8'd3, cin=0, out_ready=1 -> sum=8'd8, cout=0; out_valid high exactly 8 cycles after the accept edge, for 1 cycle.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
3. Backpressure: a=8'h3C, b=8'h0F, out_ready held low 5 cycles after out_valid -> out_valid, sum=8'h4B and cout=0 stable all 5 cycles; in_ready=0 throughout; IDLE entered on the edge after out_ready rises.
4. Reset mid-operation: rst_n pulled low 3 cycles after accepting a=8'hAA, b=8'h55 -> sum=0, cout=0, out_valid=0, busy=0 immediately. Then a=8'h10, b=8'h20 after release -> sum=8'h30, cout=0, with no residue from the aborted operation.
5. Back-to-back: in_valid held high with a new operand pair changed each accept, out_ready=1 -> accepts spaced exactly WIDTH+2 cycles apart. Operands changed while busy are ignored; each result matches its own operands.
6. Randomised: 1000 random a, b, cin at WIDTH=8 and WIDTH=13 with random out_ready stalls -> {cout, sum} == a + b + cin for every result, in order.
